// File: rtl/div_sched_ctrl.sv
// Programmable clock-enable scheduler: one period counter drives a per-period enable pulse
// and a registered divided clock. Ratio changes and stops take effect only at period boundaries.
module div_sched_ctrl #(
  parameter int unsigned CNT_W   = 8,
  parameter int unsigned DEF_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable_i,
  input  logic             div_req_i,
  input  logic [CNT_W-1:0] div_val_i,
  output logic             div_ack_o,
  output logic             div_err_o,
  output logic             busy_o,
  output logic [CNT_W-1:0] cur_div_o,
  output logic             clk_en_o,
  output logic             div_clk_o
);

  localparam logic [CNT_W-1:0] DefDiv = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] MinDiv = CNT_W'(2);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StStop
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cur_div_q, cur_div_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic             busy_q, busy_d;
  logic             clk_en_q, clk_en_d;
  logic             div_clk_q, div_clk_d;
  logic             ack_q, ack_d;
  logic             err_q, err_d;

  logic             wrap;
  logic             adopt;
  logic             running_d;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    wrap    = (state_q != StIdle) && (cnt_q == cur_div_q - CNT_W'(1));
    cnt_inc = cnt_q + CNT_W'(1);
    adopt   = busy_q && ((state_q == StIdle) || wrap);

    state_d   = state_q;
    cnt_d     = cnt_q;
    cur_div_d = cur_div_q;
    pend_d    = pend_q;
    busy_d    = busy_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (enable_i) begin
          state_d = StRun;
        end
      end
      StRun: begin
        cnt_d = wrap ? '0 : cnt_inc;
        // Disable seen on the wrap edge ends the period right here.
        if (!enable_i) begin
          state_d = wrap ? StIdle : StStop;
        end
      end
      StStop: begin
        cnt_d = wrap ? '0 : cnt_inc;
        if (enable_i) begin
          state_d = StRun;
        end else if (wrap) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase

    // Adoption only happens with busy_q set, so it never races a fresh accept.
    if (adopt) begin
      cur_div_d = pend_q;
      busy_d    = 1'b0;
      ack_d     = 1'b1;
    end else if (div_req_i && !busy_q) begin
      if (div_val_i < MinDiv) begin
        err_d = 1'b1;
      end else begin
        pend_d = div_val_i;
        busy_d = 1'b1;
      end
    end

    running_d = (state_d != StIdle);
    clk_en_d  = running_d && (cnt_d == '0);
    div_clk_d = running_d && (cnt_d < (cur_div_d >> 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      cur_div_q <= DefDiv;
      pend_q    <= DefDiv;
      busy_q    <= 1'b0;
      clk_en_q  <= 1'b0;
      div_clk_q <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cur_div_q <= cur_div_d;
      pend_q    <= pend_d;
      busy_q    <= busy_d;
      clk_en_q  <= clk_en_d;
      div_clk_q <= div_clk_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
    end
  end

  assign div_ack_o = ack_q;
  assign div_err_o = err_q;
  assign busy_o    = busy_q;
  assign cur_div_o = cur_div_q;
  assign clk_en_o  = clk_en_q;
  assign div_clk_o = div_clk_q;

endmodule

// File: tb/tb_div_sched_ctrl.sv
// Scoreboard bench for div_sched_ctrl: expected per-cycle outputs are queued as stimulus is
// applied and compared one entry per clock after each rising edge.
module tb_div_sched_ctrl;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       div_req;
  logic [7:0] div_val;
  logic       div_ack;
  logic       div_err;
  logic       busy;
  logic [7:0] cur_div;
  logic       clk_en;
  logic       div_clk;

  typedef struct packed {
    logic       clk_en;
    logic       div_clk;
    logic       ack;
    logic       err;
    logic       busy;
    logic [7:0] cur;
  } exp_t;

  exp_t  exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cycle    = 0;
  string phase    = "init";

  div_sched_ctrl #(
    .CNT_W  (8),
    .DEF_DIV(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable_i (enable),
    .div_req_i(div_req),
    .div_val_i(div_val),
    .div_ack_o(div_ack),
    .div_err_o(div_err),
    .busy_o   (busy),
    .cur_div_o(cur_div),
    .clk_en_o (clk_en),
    .div_clk_o(div_clk)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s/%s cycle=%0d: got %0d expected %0d", phase, tag, cycle, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  // Queue n cycles of a running period of ratio dv starting at counter value cnt0.
  task automatic expect_cycles(input int n, input int dv, input int cnt0, input bit bsy,
                               input bit ack0, input bit err0);
    for (int i = 0; i < n; i++) begin
      int   c;
      exp_t e;
      c         = (cnt0 + i) % dv;
      e.clk_en  = (c == 0);
      e.div_clk = (c < dv / 2);
      e.ack     = ack0 && (i == 0);
      e.err     = err0 && (i == 0);
      e.busy    = bsy;
      e.cur     = 8'(dv);
      exp_q.push_back(e);
    end
  endtask

  task automatic expect_idle(input int n, input int dv, input bit bsy, input bit ack0);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      e.clk_en  = 1'b0;
      e.div_clk = 1'b0;
      e.ack     = ack0 && (i == 0);
      e.err     = 1'b0;
      e.busy    = bsy;
      e.cur     = 8'(dv);
      exp_q.push_back(e);
    end
  endtask

  task automatic run_check(input int n);
    for (int i = 0; i < n; i++) begin
      exp_t e;
      step();
      if (exp_q.size() == 0) begin
        check_val("sb_underflow", 32'(exp_q.size()), 32'(1));
      end else begin
        e = exp_q.pop_front();
        check_val("clk_en", 32'(clk_en), 32'(e.clk_en));
        check_val("div_clk", 32'(div_clk), 32'(e.div_clk));
        check_val("div_ack", 32'(div_ack), 32'(e.ack));
        check_val("div_err", 32'(div_err), 32'(e.err));
        check_val("busy", 32'(busy), 32'(e.busy));
        check_val("cur_div", 32'(cur_div), 32'(e.cur));
      end
    end
  endtask

  task automatic check_reset();
    check_val("rst_clk_en", 32'(clk_en), 32'(0));
    check_val("rst_div_clk", 32'(div_clk), 32'(0));
    check_val("rst_ack", 32'(div_ack), 32'(0));
    check_val("rst_err", 32'(div_err), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_cur_div", 32'(cur_div), 32'(8));
  endtask

  initial begin
    rst_n   = 1'b0;
    enable  = 1'b0;
    div_req = 1'b0;
    div_val = 8'd0;
    #12;
    phase = "reset";
    check_reset();
    rst_n = 1'b1;
    expect_idle(2, 8, 1'b0, 1'b0);
    run_check(2);

    phase  = "t1_run8";
    enable = 1'b1;
    expect_cycles(16, 8, 0, 1'b0, 1'b0, 1'b0);
    run_check(16);

    phase   = "t3_err";
    div_req = 1'b1;
    div_val = 8'd1;
    expect_cycles(1, 8, 0, 1'b0, 1'b0, 1'b1);
    run_check(1);
    div_req = 1'b0;
    expect_cycles(2, 8, 1, 1'b0, 1'b0, 1'b0);
    run_check(2);

    phase   = "t2_to4";
    div_req = 1'b1;
    div_val = 8'd4;
    expect_cycles(5, 8, 3, 1'b1, 1'b0, 1'b0);
    run_check(1);
    div_req = 1'b0;
    run_check(4);
    expect_cycles(12, 4, 0, 1'b0, 1'b1, 1'b0);
    run_check(12);

    // Request lands on the wrap edge: must wait a full period of 4 before adoption.
    phase   = "t4_to5";
    div_req = 1'b1;
    div_val = 8'd5;
    expect_cycles(4, 4, 0, 1'b1, 1'b0, 1'b0);
    run_check(1);
    div_val = 8'd3;
    run_check(1);
    div_req = 1'b0;
    run_check(2);
    expect_cycles(10, 5, 0, 1'b0, 1'b1, 1'b0);
    run_check(10);

    phase = "t5_to8";
    expect_cycles(2, 5, 0, 1'b0, 1'b0, 1'b0);
    run_check(2);
    div_req = 1'b1;
    div_val = 8'd8;
    expect_cycles(3, 5, 2, 1'b1, 1'b0, 1'b0);
    run_check(1);
    div_req = 1'b0;
    run_check(2);
    expect_cycles(4, 8, 0, 1'b0, 1'b1, 1'b0);
    run_check(4);

    phase  = "t5_stop";
    enable = 1'b0;
    expect_cycles(4, 8, 4, 1'b0, 1'b0, 1'b0);
    run_check(4);
    expect_idle(1, 8, 1'b0, 1'b0);
    run_check(1);

    phase   = "t5_idle_adopt";
    div_req = 1'b1;
    div_val = 8'd6;
    expect_idle(1, 8, 1'b1, 1'b0);
    run_check(1);
    div_req = 1'b0;
    expect_idle(1, 6, 1'b0, 1'b1);
    run_check(1);
    expect_idle(1, 6, 1'b0, 1'b0);
    run_check(1);

    phase  = "t5_reenable";
    enable = 1'b1;
    expect_cycles(2, 6, 0, 1'b0, 1'b0, 1'b0);
    run_check(2);
    enable = 1'b0;
    expect_cycles(1, 6, 2, 1'b0, 1'b0, 1'b0);
    run_check(1);
    enable = 1'b1;
    expect_cycles(9, 6, 3, 1'b0, 1'b0, 1'b0);
    run_check(9);

    phase   = "t6_reset";
    div_req = 1'b1;
    div_val = 8'd3;
    expect_cycles(1, 6, 0, 1'b1, 1'b0, 1'b0);
    run_check(1);
    div_req = 1'b0;
    expect_cycles(2, 6, 1, 1'b1, 1'b0, 1'b0);
    run_check(2);
    #1;
    rst_n = 1'b0;
    #2;
    check_reset();
    rst_n = 1'b1;
    phase = "t6_after";
    expect_cycles(16, 8, 0, 1'b0, 1'b0, 1'b0);
    run_check(16);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
